// File: rtl/inst_sequencer.sv
// inst_sequencer: instruction register and timestep counter for the 10-bit
// processor. Execution advances one timestep per debounced Execute press
// (single-step) or once per clock (free-run), and retired instructions are
// counted.
module inst_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       exec_btn,
    input  logic       run_mode,
    input  logic [9:0] bus,
    input  logic       IRin,
    input  logic       Clr,
    output logic [9:0] INST,
    output logic [1:0] T,
    output logic       busy,
    output logic       done,
    output logic [7:0] retired
);

    localparam int unsigned IW  = 10;
    localparam int unsigned TW  = 2;
    localparam int unsigned RW  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW1 = CW + 1;

    // Debounce threshold, one bit wider than the counter so the compare
    // against the incremented count cannot overflow.
    localparam logic [CW1-1:0] CNT_LIMIT = CW1'(DEBOUNCE_CYCLES);

    logic          btn_s1_q, btn_s2_q;
    logic          run_s1_q, run_s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW1-1:0] cnt_inc_c;
    logic          step_q, step_d;
    logic          adv_c;
    logic [TW-1:0] t_q, t_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          done_q, done_d;
    logic [RW-1:0] ret_q, ret_d;

    // Two-flop synchronizers for the asynchronous button and switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= exec_btn;
            btn_s2_q <= btn_s1_q;
            run_s1_q <= run_mode;
            run_s2_q <= run_s1_q;
        end
    end

    assign cnt_inc_c = {1'b0, cnt_q} + CW1'(1);

    // Debouncer, step rise detector, timestep, IR and retirement next-state
    always_comb begin
        db_d   = db_q;
        cnt_d  = '0;
        t_d    = t_q;
        inst_d = inst_q;
        done_d = 1'b0;
        ret_d  = ret_q;

        if (btn_s2_q != db_q) begin
            if (cnt_inc_c == CNT_LIMIT) begin
                db_d  = btn_s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc_c[CW-1:0];
            end
        end

        // Step is high the cycle right after the debounced level rises
        step_d = db_d & ~db_q;

        adv_c = run_s2_q ? 1'b1 : step_q;

        if (adv_c) begin
            if (Clr) begin
                t_d    = '0;
                done_d = 1'b1;
                ret_d  = ret_q + RW'(1);
            end else begin
                t_d = t_q + TW'(1);
            end
            if (IRin) begin
                inst_d = bus;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q   <= 1'b0;
            cnt_q  <= '0;
            step_q <= 1'b0;
            t_q    <= '0;
            inst_q <= '0;
            done_q <= 1'b0;
            ret_q  <= '0;
        end else begin
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            t_q    <= t_d;
            inst_q <= inst_d;
            done_q <= done_d;
            ret_q  <= ret_d;
        end
    end

    assign INST    = inst_q;
    assign T       = t_q;
    assign busy    = (t_q != '0);
    assign done    = done_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: reset values, step-mode press and bounce
// latency, run-mode vector table, retirement wrap, async reset, held button
// across reset.
module tb_inst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       exec_btn;
    logic       run_mode;
    logic [9:0] bus;
    logic       IRin;
    logic       Clr;
    logic [9:0] INST;
    logic [1:0] T;
    logic       busy;
    logic       done;
    logic [7:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       irin;
        logic       clr;
        logic [9:0] bus;
        logic [1:0] t;
        logic [9:0] inst;
        logic       done;
        logic [7:0] ret;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    inst_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .exec_btn (exec_btn),
        .run_mode (run_mode),
        .bus      (bus),
        .IRin     (IRin),
        .Clr      (Clr),
        .INST     (INST),
        .T        (T),
        .busy     (busy),
        .done     (done),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // One active edge, then return to the falling edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " INST"},    32'(INST),    32'h0);
        chk({tag, " T"},       32'(T),       32'h0);
        chk({tag, " busy"},    32'(busy),    32'h0);
        chk({tag, " done"},    32'(done),    32'h0);
        chk({tag, " retired"}, 32'(retired), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 10'h101, 2'd1, 10'h101, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 10'h000, 2'd2, 10'h101, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 2'd3, 10'h101, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 10'h000, 2'd0, 10'h101, 1'b1, 8'd1};
        vecs[4]  = '{1'b1, 1'b0, 10'h202, 2'd1, 10'h202, 1'b0, 8'd1};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 2'd2, 10'h202, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 10'h000, 2'd3, 10'h202, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 10'h000, 2'd0, 10'h202, 1'b1, 8'd2};
        vecs[8]  = '{1'b1, 1'b0, 10'h303, 2'd1, 10'h303, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 10'h000, 2'd2, 10'h303, 1'b0, 8'd2};
        vecs[10] = '{1'b0, 1'b0, 10'h000, 2'd3, 10'h303, 1'b0, 8'd2};
        vecs[11] = '{1'b0, 1'b1, 10'h000, 2'd0, 10'h303, 1'b1, 8'd3};
        vecs[12] = '{1'b1, 1'b0, 10'h0AB, 2'd1, 10'h0AB, 1'b0, 8'd3};
        vecs[13] = '{1'b0, 1'b1, 10'h000, 2'd0, 10'h0AB, 1'b1, 8'd4};
        vecs[14] = '{1'b1, 1'b0, 10'h154, 2'd1, 10'h154, 1'b0, 8'd4};
        vecs[15] = '{1'b0, 1'b1, 10'h000, 2'd0, 10'h154, 1'b1, 8'd5};
        vecs[16] = '{1'b1, 1'b1, 10'h3C5, 2'd0, 10'h3C5, 1'b1, 8'd6};
        vecs[17] = '{1'b0, 1'b0, 10'h0FF, 2'd1, 10'h3C5, 1'b0, 8'd6};
        vecs[18] = '{1'b0, 1'b0, 10'h0FF, 2'd2, 10'h3C5, 1'b0, 8'd6};
        vecs[19] = '{1'b0, 1'b0, 10'h0FF, 2'd3, 10'h3C5, 1'b0, 8'd6};
        vecs[20] = '{1'b0, 1'b0, 10'h0FF, 2'd0, 10'h3C5, 1'b0, 8'd6};
        vecs[21] = '{1'b0, 1'b0, 10'h0FF, 2'd1, 10'h3C5, 1'b0, 8'd6};

        // Reset values
        rst_n = 1'b0; exec_btn = 1'b0; run_mode = 1'b0;
        bus = 10'h000; IRin = 1'b0; Clr = 1'b0;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // Clean press: T/INST update at the 7th edge (e6) after press
        bus = 10'h2A1; IRin = 1'b1; exec_btn = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 5) begin
                chk("press T@e5", 32'(T), 32'd0);
                chk("press INST@e5", 32'(INST), 32'h000);
            end
            if (e == 6) begin
                chk("press T@e6", 32'(T), 32'd1);
                chk("press INST@e6", 32'(INST), 32'h2A1);
                chk("press busy@e6", 32'(busy), 32'd1);
                bus = 10'h3FF;
            end
        end
        chk("held T", 32'(T), 32'd1);
        chk("held INST", 32'(INST), 32'h2A1);
        chk("held done", 32'(done), 32'd0);
        exec_btn = 1'b0;
        repeat (10) tick();
        chk("release T", 32'(T), 32'd1);
        chk("release INST", 32'(INST), 32'h2A1);

        // Bouncing press: toggles every 2 cycles, last rise at k=12, step lands at k=18
        bus = 10'h155;
        for (int k = 0; k < 25; k++) begin
            exec_btn = (k < 12) ? ((k % 4) < 2) : 1'b1;
            tick();
            chk($sformatf("bounce T k=%0d", k), 32'(T), (k >= 18) ? 32'd2 : 32'd1);
            if (k == 17 || k == 18)
                chk($sformatf("bounce INST k=%0d", k), 32'(INST), (k >= 18) ? 32'h155 : 32'h2A1);
        end
        exec_btn = 1'b0; IRin = 1'b0;
        repeat (10) tick();

        // Run-mode vector table starting from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_mode = 1'b1; IRin = 1'b0; Clr = 1'b0;
        tick();
        chk("run latency e0 T", 32'(T), 32'd0);
        tick();
        chk("run latency e1 T", 32'(T), 32'd0);
        for (int i = 0; i < NV; i++) begin
            IRin = vecs[i].irin; Clr = vecs[i].clr; bus = vecs[i].bus;
            tick();
            chk($sformatf("vec%0d T", i),       32'(T),       32'(vecs[i].t));
            chk($sformatf("vec%0d INST", i),    32'(INST),    32'(vecs[i].inst));
            chk($sformatf("vec%0d done", i),    32'(done),    32'(vecs[i].done));
            chk($sformatf("vec%0d retired", i), 32'(retired), 32'(vecs[i].ret));
            chk($sformatf("vec%0d busy", i),    32'(busy),    (vecs[i].t != 2'd0) ? 32'd1 : 32'd0);
        end

        // Async reset mid-instruction at T=2
        IRin = 1'b0; Clr = 1'b0;
        tick();
        chk("pre-rst T", 32'(T), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Retirement wrap: Clr every edge in run mode, 256 retirements
        Clr = 1'b1;
        tick();
        chk("wrap e0 done", 32'(done), 32'd0);
        tick();
        chk("wrap e1 done", 32'(done), 32'd0);
        chk("wrap e1 retired", 32'(retired), 32'd0);
        tick();
        chk("wrap e2 done", 32'(done), 32'd1);
        chk("wrap e2 retired", 32'(retired), 32'd1);
        repeat (254) tick();
        chk("wrap 255 retired", 32'(retired), 32'd255);
        tick();
        chk("wrap 256 retired", 32'(retired), 32'd0);
        chk("wrap 256 done", 32'(done), 32'd1);
        chk("wrap T", 32'(T), 32'd0);

        // Button held through reset: step lands 6 edges after first post-reset edge
        rst_n = 1'b0; run_mode = 1'b0; Clr = 1'b0;
        IRin = 1'b1; bus = 10'h2F0; exec_btn = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e >= 5)
                chk($sformatf("held-rst T e%0d", e), 32'(T), (e >= 6) ? 32'd1 : 32'd0);
        end
        chk("held-rst INST", 32'(INST), 32'h2F0);
        chk("held-rst retired", 32'(retired), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
